// File: rtl/score_pkg.sv
// Shared widths, limits and FSM state type for the BCD score decoder.
package score_pkg;

  localparam int unsigned SCORE_W    = 14;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [SCORE_W-1:0] MAX_SCORE = 14'd9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// One conversion step: acc*10 + digit using shifts and adds, plus the invalid-digit check.
module bcd_mac10
  import score_pkg::*;
(
  input  logic [SCORE_W-1:0] acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [SCORE_W-1:0] sum,
  output logic               bad
);

  // acc*10 == acc*8 + acc*2, truncated to the accumulator width
  always_comb begin
    sum = (acc << 3) + (acc << 1) + {{(SCORE_W-DIGIT_W){1'b0}}, digit};
    bad = (digit > 4'd9);
  end

endmodule

// File: rtl/bcd_score_decoder.sv
// Serial BCD-to-binary score converter: one digit per cycle, MSD first, saturating on bad digits.
module bcd_score_decoder
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         thousands,
  input  logic [3:0]         hundreds,
  input  logic [3:0]         tens,
  input  logic [3:0]         ones,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               digit_err
);

  state_t state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic digit_err_q, digit_err_d;

  logic [SCORE_W-1:0] acc_q, acc_d;
  logic err_q, err_d;
  logic [1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic [SCORE_W-1:0] mac_sum;
  logic               mac_bad;
  logic               last_step;
  logic               accept;

  // dig_q[3] holds thousands, so counting cnt upward walks MSD to LSD
  assign cur_digit = dig_q[2'd3 - cnt_q];
  assign last_step = (cnt_q == 2'd3);
  assign accept    = (state_q == IDLE) && start;

  bcd_mac10 u_mac (
    .acc   (acc_q),
    .digit (cur_digit),
    .sum   (mac_sum),
    .bad   (mac_bad)
  );

  // FSM next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    score_d     = score_q;
    digit_err_d = digit_err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = CONV;
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        busy_d = 1'b1;
        if (last_step) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          digit_err_d = err_q | mac_bad;
          score_d     = (err_q | mac_bad) ? MAX_SCORE : mac_sum;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      score_q     <= '0;
      digit_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      score_q     <= score_d;
      digit_err_q <= digit_err_d;
    end
  end

  // Datapath next-state: latch digits on accept, accumulate during conversion
  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    dig_d = dig_q;
    if (accept) begin
      dig_d = {thousands, hundreds, tens, ones};
      acc_d = '0;
      err_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == CONV) begin
      acc_d = mac_sum;
      err_d = err_q | mac_bad;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign score     = score_q;
  assign digit_err = digit_err_q;

endmodule

// File: tb/tb_bcd_score_decoder.sv
// Self-checking bench for bcd_score_decoder against a decimal-arithmetic reference model.
module tb_bcd_score_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done, digit_err;
  logic [13:0] score;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bcd_score_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .score     (score),
    .digit_err (digit_err)
  );

  // Reference: plain decimal weighting, saturating to 9999 on any non-decimal digit
  function automatic bit ref_err(input int t, input int h, input int te, input int o);
    return (t > 9) || (h > 9) || (te > 9) || (o > 9);
  endfunction

  function automatic int ref_score(input int t, input int h, input int te, input int o);
    if (ref_err(t, h, te, o)) return 9999;
    return t * 1000 + h * 100 + te * 10 + o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present digits with start for one sampling edge; returns #1 after that edge
  task automatic start_conv(input int t, input int h, input int te, input int o);
    thousands = 4'(t);
    hundreds  = 4'(h);
    tens      = 4'(te);
    ones      = 4'(o);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Edges after the start edge until done is seen; 0 means no done within the budget
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, digit_err, score} !== 17'd0) begin
      n_fails++;
      $display("FAIL reset_state: busy=%b done=%b err=%b score=%0d, required all zero",
               busy, done, digit_err, score);
    end
  endtask

  task automatic test_basic();
    start_conv(1, 2, 3, 4);
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fails++;
        $display("FAIL basic_busy_cycle%0d: busy=%b done=%b, required busy=1 done=0", i, busy, done);
      end
      if (i < 4) step();
    end
    step();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || score !== 14'd1234 || digit_err !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_done: done=%b busy=%b score=%0d err=%b, required 1 0 1234 0",
               done, busy, score, digit_err);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || score !== 14'd1234) begin
      n_fails++;
      $display("FAIL basic_after_done: done=%b score=%0d, required done=0 score=1234", done, score);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    int pulses;
    int vals [2] = '{9, 0};
    foreach (vals[j]) begin
      step();
      start_conv(vals[j], vals[j], vals[j], vals[j]);
      wait_done(cyc);
      n_checks++;
      if (cyc != 4 || score !== 14'(ref_score(vals[j], vals[j], vals[j], vals[j])) || digit_err !== 1'b0) begin
        n_fails++;
        $display("FAIL extreme_%0d: latency=%0d score=%0d err=%b, required 4 %0d 0",
                 vals[j], cyc, score, digit_err, ref_score(vals[j], vals[j], vals[j], vals[j]));
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
        n_fails++;
        $display("FAIL extreme_%0d_single_pulse: extra pulses=%0d, required 0", vals[j], pulses);
      end
    end
  endtask

  task automatic test_error();
    int cyc;
    start_conv(1, 2, 10, 4);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || score !== 14'd9999 || digit_err !== 1'b1) begin
      n_fails++;
      $display("FAIL error_digit: latency=%0d score=%0d err=%b, required 4 9999 1",
               cyc, score, digit_err);
    end
    step();
  endtask

  task automatic test_start_during_conv();
    int first;
    int pulses;
    first = 0;
    pulses = 0;
    start_conv(1, 2, 3, 4);
    step();
    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = i;
          n_checks++;
          if (score !== 14'd1234 || digit_err !== 1'b0) begin
            n_fails++;
            $display("FAIL start_in_conv_score: score=%0d err=%b, required 1234 0", score, digit_err);
          end
        end
      end
    end
    n_checks++;
    if (pulses != 1 || first != 4) begin
      n_fails++;
      $display("FAIL start_in_conv_pulses: pulses=%0d first_at=%0d, required 1 at 4", pulses, first);
    end
  endtask

  task automatic test_reset_mid_conv();
    int cyc;
    int pulses;
    pulses = 0;
    start_conv(1, 2, 3, 4);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (score !== 14'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_conv: score=%0d busy=%b done=%b, required 0 0 0", score, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fails++;
      $display("FAIL reset_aborts: done pulses=%0d, required 0", pulses);
    end
    start_conv(0, 0, 4, 2);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || score !== 14'd42 || digit_err !== 1'b0) begin
      n_fails++;
      $display("FAIL after_reset_conv: latency=%0d score=%0d err=%b, required 4 42 0",
               cyc, score, digit_err);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    step();
    start_conv(3, 1, 4, 1);
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || score !== 14'd3141) begin
      n_fails++;
      $display("FAIL b2b_first: latency=%0d score=%0d, required 4 3141", cyc, score);
    end
    // this start lands on the DONE cycle and must be ignored
    thousands = 4'd9; hundreds = 4'd8; tens = 4'd7; ones = 4'd6;
    start = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_start_in_done: busy=%b done=%b, required 0 0", busy, done);
    end
    thousands = 4'd5; hundreds = 4'd4; tens = 4'd3; ones = 4'd2;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 4 || score !== 14'd5432 || digit_err !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_second: latency=%0d score=%0d err=%b, required 4 5432 0",
               cyc, score, digit_err);
    end
    step();
  endtask

  task automatic test_random();
    int d [4];
    int cyc;
    int exp_s;
    bit exp_e;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++)
        d[k] = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
      exp_s = ref_score(d[0], d[1], d[2], d[3]);
      exp_e = ref_err(d[0], d[1], d[2], d[3]);
      start_conv(d[0], d[1], d[2], d[3]);
      // scramble inputs after the sampling edge; the latched copy must win
      thousands = 4'($urandom); hundreds = 4'($urandom);
      tens      = 4'($urandom); ones     = 4'($urandom);
      wait_done(cyc);
      n_checks++;
      if (cyc != 4 || score !== 14'(exp_s) || digit_err !== exp_e) begin
        n_fails++;
        $display("FAIL random_%0d digits %0d %0d %0d %0d: latency=%0d score=%0d err=%b, required 4 %0d %b",
                 n, d[0], d[1], d[2], d[3], cyc, score, digit_err, exp_s, exp_e);
      end
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        thousands = 4'($urandom);
        step();
      end
      n_checks++;
      if (score !== 14'(exp_s) || digit_err !== exp_e || busy !== 1'b0) begin
        n_fails++;
        $display("FAIL random_%0d_hold: score=%0d err=%b busy=%b, required %0d %b 0",
                 n, score, digit_err, busy, exp_s, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_error();
    test_start_during_conv();
    test_reset_mid_conv();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_score_decoder.md
BCD_SCORE_DECODER -- requirements
Module: bcd_score_decoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: system clock; all state changes on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: request a conversion of the digit inputs; sampled only in IDLE.
REQ-004 The block SHALL have the port thousands, input, 4 bits: BCD thousands digit.
REQ-005 The block SHALL have the port hundreds, input, 4 bits: BCD hundreds digit.
REQ-006 The block SHALL have the port tens, input, 4 bits: BCD tens digit.
REQ-007 The block SHALL have the port ones, input, 4 bits: BCD ones digit.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while a conversion is in progress (CONV state).
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking that score and digit_err are updated.
REQ-010 The block SHALL have the port score, output, 14 bits: binary result, range 0..9999.
REQ-011 The block SHALL have the port digit_err, output, 1 bit: the last conversion saw a digit greater than 9.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch all four digits, clear the accumulator and error flag, clear the digit counter and enter CONV.
REQ-014 In CONV, each edge SHALL process one latched digit, MSD first (thousands, hundreds, tens, ones): acc <= acc*10 + digit.
REQ-015 The multiply by 10 SHALL be implemented as (acc<<3)+(acc<<1) at 14-bit width; no divider or generic multiplier SHALL be used.
REQ-016 At edge k+4 the block SHALL write the final accumulator to score, set done=1 and enter DONE, giving a latency of 4 cycles from start sampling to done.
REQ-017 DONE SHALL last exactly one cycle, after which the block SHALL return to IDLE unconditionally with done=0.
REQ-018 A start asserted during DONE SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.
REQ-019 start SHALL be ignored while busy=1, and the latched digits SHALL be unaffected by input changes after edge k.
REQ-020 Any latched digit greater than 9 SHALL set the error flag.
REQ-021 On an error conversion, score SHALL be 9999 (saturated) and digit_err=1 at done.
REQ-022 On a valid conversion, digit_err SHALL be 0 at done.
REQ-023 score and digit_err SHALL hold their values between conversions and SHALL change only at the done edge or on reset.
REQ-024 busy SHALL equal 1 exactly in CONV.
REQ-025 The accumulator SHALL never exceed 9999 for valid digits; no overflow handling is needed beyond REQ-021.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set state=IDLE, score=0, digit_err=0, done=0, busy=0, and clear the accumulator and counter.
REQ-027 Reset SHALL take priority over start and over any CONV or DONE activity.
REQ-028 A conversion interrupted by reset SHALL be aborted with no done pulse.

Structure
REQ-029 A shared package score_pkg SHALL hold SCORE_W=14, DIGIT_W=4, MAX_SCORE=9999 and the state enum type.
REQ-030 The combinational step acc*10+digit, together with the digit>9 check, SHALL be a sub-module named bcd_mac10, instantiated once.
REQ-031 The design SHALL contain one FSM process plus one datapath register process.

Verification
REQ-032 Digits 1,2,3,4 with start -> busy high for 4 cycles; done pulses at cycle 4 with score=1234 and digit_err=0.
REQ-033 Digits 9,9,9,9 -> score=9999; digits 0,0,0,0 -> score=0; done pulses once for each.
REQ-034 tens=0xA with other digits 1,2,_,4 -> done with score=9999 and digit_err=1.
REQ-035 Start a conversion of 1234, pulse start again with digits 5,6,7,8 at CONV cycle 2 -> result is 1234 and only one done pulse occurs.
REQ-036 Assert reset at CONV cycle 2 -> next cycle has score=0, busy=0 and no done pulse; a following start of 0042 yields score=42.
REQ-037 Issue start on the first IDLE cycle after done -> second conversion is accepted and completes 4 cycles later.
